blsync_rx_ber: RTL and testbench
================================

Name: blsync_rx_ber

Overview:
Parametrised successor of the RX block-sync stage in the 32-bit PCS receive path. It sits between the RX aligner (2-bit sync header plus header strobe) and the PMA slip/sync controls.
- Adds configurable lock-window sizes and a post-slip hold-off, so slip pulses match the PMA's slip latency.
- Adds a Clause-49-style BER monitor: hi_ber flag and per-window invalid-header count for the downstream descrambler/decoder and for status.

Parameters:
SH_WINDOW, 64, headers per lock test window (range 2..1023)
SH_INVLD_MAX, 16, invalid headers within one window that drop lock while locked (1..SH_WINDOW)
SLIP_WAIT, 32, clock cycles after a slip pulse during which headers are ignored (1..65535)
BER_TIMER, 19531, BER window length in clock cycles (2..2^20)
BER_THRESH, 16, invalid headers within one BER window that set hi_ber (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
header  in  2  sync header of the current 66b block
header_ena  in  1  header valid strobe, one cycle per block
block_lock  out  1  block lock achieved (to pma_sync)
slip  out  1  one-cycle slip request to PMA/aligner
hi_ber  out  1  high bit-error-rate indication
ber_cnt  out  $clog2(BER_THRESH+1)  invalid headers in the current BER window, saturating at BER_THRESH

Behaviour:
- A header is valid iff header[1]^header[0] = 1 (2'b01 or 2'b10). Headers are considered only on cycles with header_ena=1.
- All outputs are registered.
- Reset, applied on any cycle including mid-window or mid-wait:
  - block_lock=0, slip=0, hi_ber=0, ber_cnt=0.
  - sh_cnt=0, invld_cnt=0, wait counter=0, BER timer=0.
  - State TEST.
- Lock FSM states: TEST, SLIP, WAIT.
- TEST, on each header_ena:
  - sh_cnt += 1; invld_cnt += 1 if the header is invalid.
- TEST while unlocked (block_lock=0):
  - Invalid header -> next state SLIP.
  - Valid header that makes sh_cnt = SH_WINDOW -> block_lock=1 next cycle; sh_cnt and invld_cnt cleared.
- TEST while locked (block_lock=1):
  - invld_cnt reaches SH_INVLD_MAX -> block_lock=0 and next state SLIP. This takes priority over window end.
  - Otherwise sh_cnt reaching SH_WINDOW -> both counters cleared; stay locked.
- SLIP (one cycle):
  - slip=1 for exactly this cycle; block_lock=0.
  - Counters cleared.
  - Next state WAIT.
- WAIT:
  - Count SLIP_WAIT cycles; header_ena is ignored.
  - At the end of the count -> TEST with counters cleared.
- Latency: slip is asserted 2 cycles after the triggering header_ena cycle (registered FSM -> SLIP state). block_lock rises 1 cycle after the SH_WINDOW-th valid header.
- Slip pulses are spaced at least SLIP_WAIT+2 cycles apart. slip is never asserted for 2 consecutive cycles.
- BER monitor runs only while block_lock=1.
- When block_lock=0: timer, ber_cnt and hi_ber are held at 0.
- BER timer: counts clock cycles 0..BER_TIMER-1, then wraps. The wrap cycle ends the window.
- Invalid header with header_ena, not on a wrap cycle: ber_cnt += 1, saturating at BER_THRESH.
- When ber_cnt reaches BER_THRESH: hi_ber=1 on the following cycle. It is not held off until window end.
- On the wrap cycle:
  - hi_ber <= (ber_cnt == BER_THRESH), evaluated on the count before this cycle's header.
  - ber_cnt <= 1 if this cycle carries an invalid header, else 0.
- Lock loss mid-window clears BER state on the next cycle. The next lock restarts the timer from 0.
- Width rule: all internal counters are sized via $clog2 of their parameter. No wrap occurs within the legal parameter ranges.

Test Plan:
- Lock acquisition: reset, then 64 valid headers (2'b01/2'b10 alternating) at one per cycle -> block_lock=1 exactly 1 cycle after the 64th header; slip never asserted.
- Slip while unlocked: after reset, header=2'b00 on the 10th strobe -> slip=1 for one cycle, 2 cycles later. With continuous invalid headers, the next slip comes 34 cycles after the first (SLIP_WAIT=32). Headers during WAIT do not advance sh_cnt.
- Lock loss:
  - While locked, 16 invalid headers within one 64-header window -> block_lock=0 and one slip pulse.
  - 15 invalid headers per window over 4 windows -> lock retained.
- BER:
  - Setup: locked, BER_TIMER=100 via override.
  - 16 invalid headers in one window -> hi_ber=1 the cycle after the 16th; ber_cnt saturates at 16.
  - A following window with 3 invalid headers -> hi_ber=0 at its wrap; ber_cnt=0 after the wrap.
- Boundary: invalid header on the BER wrap cycle -> ber_cnt=1 afterwards, and the hi_ber decision ignores that header. Invalid header on the cycle sh_cnt hits 64 with invld_cnt=15 -> lock lost (priority rule).
- Reset mid-WAIT and mid-lock: rst pulsed for 1 cycle -> all outputs 0 the next cycle; re-lock requires a full 64 valid headers.

Source files
------------

// File: rtl/blsync_rx_ber.sv
`default_nettype none
// ============================================================================
//  Module   : blsync_rx_ber
//  Purpose  : Block-sync state machine for the 32-bit PCS receive path with
//             a BER monitor. Watches the 2-bit sync header from the RX
//             aligner. It asserts block_lock once a full window of valid
//             headers has been seen. It requests bit slips from the PMA
//             while unlocked or after lock is lost. While locked, it counts
//             invalid headers per BER window and flags a high bit-error rate.
//  Ports    :
//    clk         in   clock
//    rst         in   synchronous reset, active-high
//    header      in   [1:0] sync header of the current 66b block
//    header_ena  in   header valid strobe, one cycle per block
//    block_lock  out  block lock achieved (to pma_sync)
//    slip        out  one-cycle slip request to PMA/aligner
//    hi_ber      out  high bit-error-rate indication
//    ber_cnt     out  invalid headers in the current BER window (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module blsync_rx_ber #(
    parameter int SH_WINDOW    = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32,
    parameter int BER_TIMER    = 19531,
    parameter int BER_THRESH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        header,
    input  logic                              header_ena,
    output logic                              block_lock,
    output logic                              slip,
    output logic                              hi_ber,
    output logic [$clog2(BER_THRESH+1)-1:0]   ber_cnt
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_sh_w = $clog2(SH_WINDOW + 1);
    localparam int c_iv_w = $clog2(SH_INVLD_MAX + 1);
    localparam int c_wt_w = $clog2(SLIP_WAIT + 1);
    localparam int c_tm_w = $clog2(BER_TIMER);
    localparam int c_bc_w = $clog2(BER_THRESH + 1);

    localparam logic [c_sh_w-1:0] c_sh_window  = c_sh_w'(SH_WINDOW);
    localparam logic [c_iv_w-1:0] c_invld_max  = c_iv_w'(SH_INVLD_MAX);
    localparam logic [c_wt_w-1:0] c_wait_last  = c_wt_w'(SLIP_WAIT - 1);
    localparam logic [c_tm_w-1:0] c_timer_last = c_tm_w'(BER_TIMER - 1);
    localparam logic [c_bc_w-1:0] c_ber_thresh = c_bc_w'(BER_THRESH);

    // Lock FSM encoding
    localparam logic [1:0] c_st_test = 2'd0;
    localparam logic [1:0] c_st_slip = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_sh_w-1:0] r_sh_cnt;
    logic [c_iv_w-1:0] r_invld_cnt;
    logic [c_wt_w-1:0] r_wait_cnt;
    logic              r_block_lock;
    logic              r_slip;

    logic [c_tm_w-1:0] r_ber_timer;
    logic [c_bc_w-1:0] r_ber_cnt;
    logic              r_hi_ber;

    // ------------------------------------------------------------------
    // Header classification
    // ------------------------------------------------------------------
    logic              w_hdr_invalid;
    logic              w_bad_hdr;
    logic [c_sh_w-1:0] w_sh_cnt_inc;
    logic [c_iv_w-1:0] w_invld_cnt_inc;

    // Only 2'b01 and 2'b10 are legal sync headers
    assign w_hdr_invalid   = ~(header[1] ^ header[0]);
    assign w_bad_hdr       = header_ena & w_hdr_invalid;
    assign w_sh_cnt_inc    = r_sh_cnt + c_sh_w'(1);
    assign w_invld_cnt_inc = r_invld_cnt + c_iv_w'(w_hdr_invalid);

    // ------------------------------------------------------------------
    // Lock FSM: TEST -> SLIP -> WAIT -> TEST
    // slip is registered from the SLIP state, so the pulse appears two
    // cycles after the header that caused it and lasts one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_test;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                c_st_test: begin
                    if (header_ena) begin
                        if (!r_block_lock) begin
                            // Unlocked: any bad header forces a slip;
                            // a full window of good headers gives lock.
                            if (w_hdr_invalid) begin
                                r_state <= c_st_slip;
                            end else if (w_sh_cnt_inc == c_sh_window) begin
                                r_block_lock <= 1'b1;
                                r_sh_cnt     <= '0;
                                r_invld_cnt  <= '0;
                            end else begin
                                r_sh_cnt <= w_sh_cnt_inc;
                            end
                        end else begin
                            // Locked: the invalid limit wins over the
                            // window end when both occur on one header.
                            if (w_invld_cnt_inc == c_invld_max) begin
                                r_block_lock <= 1'b0;
                                r_state      <= c_st_slip;
                            end else if (w_sh_cnt_inc == c_sh_window) begin
                                r_sh_cnt    <= '0;
                                r_invld_cnt <= '0;
                            end else begin
                                r_sh_cnt    <= w_sh_cnt_inc;
                                r_invld_cnt <= w_invld_cnt_inc;
                            end
                        end
                    end
                end

                c_st_slip: begin
                    r_slip       <= 1'b1;
                    r_block_lock <= 1'b0;
                    r_sh_cnt     <= '0;
                    r_invld_cnt  <= '0;
                    r_wait_cnt   <= '0;
                    r_state      <= c_st_wait;
                end

                c_st_wait: begin
                    // Headers are ignored while the PMA applies the slip
                    if (r_wait_cnt == c_wait_last) begin
                        r_wait_cnt  <= '0;
                        r_sh_cnt    <= '0;
                        r_invld_cnt <= '0;
                        r_state     <= c_st_test;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wt_w'(1);
                    end
                end

                default: begin
                    r_state <= c_st_test;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // BER monitor, active only while locked. Each window ends on the
    // timer wrap cycle; that cycle's hi_ber decision uses the count from
    // before its own header, which then seeds the next window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !r_block_lock) begin
            r_ber_timer <= '0;
            r_ber_cnt   <= '0;
            r_hi_ber    <= 1'b0;
        end else if (r_ber_timer == c_timer_last) begin
            r_ber_timer <= '0;
            r_hi_ber    <= (r_ber_cnt == c_ber_thresh);
            r_ber_cnt   <= w_bad_hdr ? c_bc_w'(1) : '0;
        end else begin
            r_ber_timer <= r_ber_timer + c_tm_w'(1);
            // hi_ber follows saturation immediately, not at window end
            if (r_ber_cnt == c_ber_thresh) begin
                r_hi_ber <= 1'b1;
            end else if (w_bad_hdr) begin
                r_ber_cnt <= r_ber_cnt + c_bc_w'(1);
            end
        end
    end

    assign block_lock = r_block_lock;
    assign slip       = r_slip;
    assign hi_ber     = r_hi_ber;
    assign ber_cnt    = r_ber_cnt;

endmodule
`default_nettype wire

// File: tb/tb_blsync_rx_ber.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blsync_rx_ber
//  Purpose  : Directed self-checking bench for blsync_rx_ber (BER window
//             shortened to 100 cycles). Inputs change 1 ns after each rising
//             edge; outputs are read at the same point, so every value seen
//             reflects the edge that sampled the previously driven header.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blsync_rx_ber;

    localparam int c_ber_timer = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] header;
    logic       header_ena;
    logic       block_lock;
    logic       slip;
    logic       hi_ber;
    logic [4:0] ber_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    blsync_rx_ber #(
        .SH_WINDOW   (64),
        .SH_INVLD_MAX(16),
        .SLIP_WAIT   (32),
        .BER_TIMER   (c_ber_timer),
        .BER_THRESH  (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .header    (header),
        .header_ena(header_ena),
        .block_lock(block_lock),
        .slip      (slip),
        .hi_ber    (hi_ber),
        .ber_cnt   (ber_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, wait for the edge, settle
    task automatic cyc(input logic [1:0] h, input logic e);
        header     = h;
        header_ena = e;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] vh(input int i);
        return i[0] ? 2'b10 : 2'b01;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc(2'b01, 1'b0);
        rst = 1'b0;
    endtask

    task automatic acquire_lock();
        for (int i = 0; i < 64; i++) cyc(vh(i), 1'b1);
    endtask

    function automatic bit ber_bad(input int j);
        return (j >= 50 && j <= 67) || (j >= 110 && j <= 112) || (j == 200) ||
               (j >= 260 && j <= 273) || (j == 300);
    endfunction

    initial begin
        int slip_seen;
        int first_idx;
        int lost;

        rst        = 1'b1;
        header     = 2'b01;
        header_ena = 1'b0;

        // Reset state
        do_reset();
        check("rst_lock",   int'(block_lock), 0);
        check("rst_slip",   int'(slip),       0);
        check("rst_hi_ber", int'(hi_ber),     0);
        check("rst_ber_cnt", int'(ber_cnt),   0);

        // Lock acquisition: lock exactly after the 64th valid header
        slip_seen = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(vh(i), 1'b1);
            slip_seen += int'(slip);
            if (i == 62) check("acq_lock_at63", int'(block_lock), 0);
        end
        check("acq_lock_at64", int'(block_lock), 1);
        check("acq_no_slip",   slip_seen,        0);

        // Slip while unlocked: bad 10th header, slip 2 cycles later,
        // next slip 34 cycles after with continuous bad headers
        do_reset();
        for (int i = 0; i < 9; i++) cyc(vh(i), 1'b1);
        cyc(2'b00, 1'b1);
        check("slip_lat_1", int'(slip), 0);
        cyc(2'b00, 1'b1);
        check("slip_lat_2", int'(slip), 1);
        first_idx = -1;
        slip_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(2'b00, 1'b1);
            if (slip) begin
                slip_seen++;
                if (first_idx < 0) first_idx = i;
            end
        end
        check("slip_spacing", first_idx, 34);
        check("slip_count",   slip_seen, 1);

        // Headers during SLIP/WAIT are ignored: 33 ignored + 64 counted
        do_reset();
        cyc(2'b00, 1'b1);
        for (int i = 1; i <= 97; i++) begin
            cyc(vh(i), 1'b1);
            if (i == 96) check("wait_ign_pre", int'(block_lock), 0);
        end
        check("wait_ign_lock", int'(block_lock), 1);

        // Lock loss: 16 bad headers in one window
        do_reset();
        acquire_lock();
        for (int i = 1; i <= 16; i++) begin
            cyc(2'b11, 1'b1);
            if (i == 15) check("loss_hold15", int'(block_lock), 1);
        end
        check("loss_lock",    int'(block_lock), 0);
        check("loss_ber_cnt", int'(ber_cnt),    16);
        cyc(vh(0), 1'b1);
        check("loss_slip",     int'(slip),    1);
        check("loss_ber_clr",  int'(ber_cnt), 0);
        check("loss_hi_clr",   int'(hi_ber),  0);
        slip_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(vh(i), 1'b1);
            slip_seen += int'(slip);
        end
        check("loss_one_slip", slip_seen, 0);

        // 15 bad headers per window over 4 windows keeps lock
        do_reset();
        acquire_lock();
        lost      = 0;
        slip_seen = 0;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 64; i++) begin
                cyc((i < 15) ? 2'b00 : vh(i), 1'b1);
                lost      += int'(!block_lock);
                slip_seen += int'(slip);
            end
        end
        check("keep_lock", lost,      0);
        check("keep_slip", slip_seen, 0);

        // Priority: 16th bad header is also the 64th header of the window
        do_reset();
        acquire_lock();
        for (int i = 0; i < 63; i++) cyc((i < 15) ? 2'b00 : vh(i), 1'b1);
        check("prio_pre", int'(block_lock), 1);
        cyc(2'b00, 1'b1);
        check("prio_lock", int'(block_lock), 0);
        cyc(vh(0), 1'b1);
        check("prio_slip", int'(slip), 1);

        // BER monitor: wraps at j = 100, 200, 300 after lock
        do_reset();
        acquire_lock();
        for (int j = 1; j <= 300; j++) begin
            cyc(ber_bad(j) ? 2'b00 : vh(j), 1'b1);
            case (j)
                64:  check("ber_cnt15", int'(ber_cnt), 15);
                65: begin
                    check("ber_cnt16",   int'(ber_cnt), 16);
                    check("ber_hi_wait", int'(hi_ber),  0);
                end
                66:  check("ber_hi_set",  int'(hi_ber),  1);
                67:  check("ber_sat",     int'(ber_cnt), 16);
                99: begin
                    check("ber_hi_hold", int'(hi_ber),  1);
                    check("ber_sat_end", int'(ber_cnt), 16);
                end
                100: begin
                    check("wrap1_hi",  int'(hi_ber),  1);
                    check("wrap1_cnt", int'(ber_cnt), 0);
                end
                112: check("win2_cnt3",  int'(ber_cnt), 3);
                199: check("win2_hi",    int'(hi_ber),  1);
                200: begin
                    check("wrap2_hi",  int'(hi_ber),  0);
                    check("wrap2_cnt", int'(ber_cnt), 1);
                end
                299: begin
                    check("win3_cnt15", int'(ber_cnt), 15);
                    check("win3_hi",    int'(hi_ber),  0);
                end
                300: begin
                    check("wrap3_hi",  int'(hi_ber),  0);
                    check("wrap3_cnt", int'(ber_cnt), 1);
                end
                default: ;
            endcase
        end
        check("ber_lock_kept", int'(block_lock), 1);

        // Reset in the middle of WAIT, then a full re-lock is needed
        do_reset();
        cyc(2'b00, 1'b1);
        cyc(vh(0), 1'b1);
        check("mw_slip", int'(slip), 1);
        for (int i = 0; i < 4; i++) cyc(vh(i), 1'b1);
        rst = 1'b1;
        cyc(vh(0), 1'b1);
        rst = 1'b0;
        check("mw_rst_slip", int'(slip),       0);
        check("mw_rst_lock", int'(block_lock), 0);
        for (int i = 0; i < 64; i++) begin
            cyc(vh(i), 1'b1);
            if (i == 62) check("mw_relock_pre", int'(block_lock), 0);
        end
        check("mw_relock", int'(block_lock), 1);

        // Reset while locked with hi_ber set
        do_reset();
        acquire_lock();
        for (int j = 1; j <= 70; j++) cyc((j >= 50 && j <= 65) ? 2'b00 : vh(j), 1'b1);
        check("ml_hi_pre", int'(hi_ber), 1);
        rst = 1'b1;
        cyc(vh(0), 1'b1);
        rst = 1'b0;
        check("ml_rst_lock", int'(block_lock), 0);
        check("ml_rst_hi",   int'(hi_ber),     0);
        check("ml_rst_cnt",  int'(ber_cnt),    0);
        check("ml_rst_slip", int'(slip),       0);
        for (int i = 0; i < 64; i++) begin
            cyc(vh(i), 1'b1);
            if (i == 62) check("ml_relock_pre", int'(block_lock), 0);
        end
        check("ml_relock", int'(block_lock), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
